// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - core load/store to valid/ready data RAM bridge with byte strobes and core stall
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req, we, mem_ctrl     core load/store request, store flag, width code
//   addr, wdata           byte address and store data from the datapath
//   rdata                 registered raw read word back to the datapath
//   core_stall            holds the core while the access is outstanding
//   misaligned, bus_err   one-cycle pulses in DONE (rejected / timed out)
//   mem_valid, mem_ready  bus handshake
//   mem_write, mem_addr, mem_wdata, mem_wstrb, mem_rdata   bus payload
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES wait cycles; otherwise REQ waits indefinitely and bus_err is 0.

module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        core_stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state;

    logic        is_word;
    logic        is_half;
    logic        mis_now;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;

    // Width decode; unsigned codes share alignment rules with their signed
    // counterparts, and any unused code is treated as a byte access.
    always_comb begin
        is_word = (mem_ctrl == 3'b010);
        is_half = (mem_ctrl[1:0] == 2'b01);
        mis_now = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
        if (is_word) begin
            strb_n  = 4'b1111;
            wdata_n = wdata;
        end else if (is_half) begin
            strb_n  = addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{wdata[15:0]}};
        end else begin
            strb_n  = 4'b0001 << addr[1:0];
            wdata_n = {4{wdata[7:0]}};
        end
    end

    // Stall is released in DONE so the core retires at the end of that cycle.
    assign core_stall = req & (state != DONE) & ~reset;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       bus_err_q;
    assign bus_err = bus_err_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            mem_write  <= 1'b0;
            mem_wstrb  <= 4'b0000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            rdata      <= 32'h0;
            misaligned <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt   <= 8'h0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (mis_now) begin
                            // Rejected without touching the bus.
                            state      <= DONE;
                            misaligned <= 1'b1;
                            rdata      <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_write <= we;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wdata_n;
                            mem_wstrb <= we ? strb_n : 4'b0000;
`ifdef DMEM_TIMEOUT_EN
                            wait_cnt  <= 8'h0;
`endif
                        end
                    end
                end
                REQ: begin
                    // Ready has priority over a timeout in the same cycle.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!mem_write) begin
                            rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        mem_valid <= 1'b0;
                        rdata     <= 32'h0;
                        bus_err_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
`endif
                end
                DONE: begin
                    state      <= IDLE;
                    misaligned <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    bus_err_q  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - scoreboard bench for dmem_bridge

module tb_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        core_stall;
    logic        misaligned;
    logic        bus_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        write;
        logic        mis;
        logic        berr;
        int          stall;
    } exp_t;

    exp_t sb[$];

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .mem_ctrl   (mem_ctrl),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .core_stall (core_stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] st, input logic w, input logic m,
                                input logic be, input int stl);
        exp_t e;
        e.rdata = r; e.addr = a; e.wdata = wd; e.wstrb = st;
        e.write = w; e.mis = m; e.berr = be; e.stall = stl;
        return e;
    endfunction

    // waits < 0 means the RAM never answers.
    task automatic run_txn(input logic w, input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] bus_rd,
                           input int waits, input exp_t e);
        exp_t ex;
        int   stall_n = 0;
        int   wait_n = 0;
        bit   done = 0;
        bit   saw_valid = 0;
        sb.push_back(e);
        req = 1'b1; we = w; mem_ctrl = ctrl; addr = a; wdata = wd; mem_ready = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (core_stall) begin
                stall_n++;
                if (mem_valid) begin
                    saw_valid = 1;
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                    check("mem_wdata", mem_wdata, e.wdata);
                    check("mem_write", 32'(mem_write), 32'(e.write));
                    if (waits >= 0 && wait_n == waits) begin
                        mem_ready = 1'b1;
                        mem_rdata = bus_rd;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = 32'hBAD0BAD0;
                        wait_n++;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                done = 1;
                ex = sb.pop_front();
                check("rdata", rdata, ex.rdata);
                check("misaligned", 32'(misaligned), 32'(ex.mis));
                check("bus_err", 32'(bus_err), 32'(ex.berr));
                check("stall_cycles", 32'(stall_n), 32'(ex.stall));
                check("bus_used", 32'(saw_valid), 32'(!ex.mis));
                check("valid_in_done", 32'(mem_valid), 32'h0);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            check("txn_timeout", 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("mis_pulse_end", 32'(misaligned), 32'h0);
        check("berr_pulse_end", 32'(bus_err), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; mem_ctrl = 3'b010; addr = 32'h0;
        wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_core_stall", 32'(core_stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Load word, zero wait.
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                mk(32'hDEADBEEF, 32'h100, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 2));

        // Ready while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(mem_valid), 32'h0);
            check("idle_rdata", rdata, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;

        // Store byte to lane 3.
        run_txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0,
                mk(32'hDEADBEEF, 32'h200, 32'hA5A5A5A5, 4'b1000, 1'b1, 1'b0, 1'b0, 2));

        // Store half, upper lanes, three wait cycles.
        run_txn(1'b1, 3'b001, 32'h302, 32'h00001234, 32'h0, 3,
                mk(32'hDEADBEEF, 32'h300, 32'h12341234, 4'b1100, 1'b1, 1'b0, 1'b0, 5));

        // Reset in the second wait cycle of REQ.
        req = 1'b1; we = 1'b0; mem_ctrl = 3'b010; addr = 32'h400; wdata = 32'h0; mem_ready = 1'b0;
        @(negedge clk);
        check("rr_c0_stall", 32'(core_stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_w1_valid", 32'(mem_valid), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_w2_valid", 32'(mem_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("rr_stall_in_reset", 32'(core_stall), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_valid", 32'(mem_valid), 32'h0);
        check("rr_rdata", rdata, 32'h0);
        check("rr_stall", 32'(core_stall), 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rr_idle_valid", 32'(mem_valid), 32'h0);
        @(posedge clk); #1;

        // Load half-unsigned, one wait.
        run_txn(1'b0, 3'b101, 32'h106, 32'h0, 32'hCAFE0123, 1,
                mk(32'hCAFE0123, 32'h104, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3));

        // Misaligned word load.
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0,
                mk(32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1));

        // Misaligned half store.
        run_txn(1'b1, 3'b001, 32'h303, 32'h0000BEEF, 32'h0, 0,
                mk(32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1));

        // Byte store to lane 1, one wait.
        run_txn(1'b1, 3'b000, 32'h001, 32'h00000077, 32'h0, 1,
                mk(32'h0, 32'h0, 32'h77777777, 4'b0010, 1'b1, 1'b0, 1'b0, 3));

        // Silent RAM.
`ifdef DMEM_TIMEOUT_EN
        run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1,
                mk(32'h0, 32'h500, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 5));
`else
        begin
            int stall_n = 0;
            int berr_n = 0;
            req = 1'b1; we = 1'b0; mem_ctrl = 3'b010; addr = 32'h500; mem_ready = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (core_stall) stall_n++;
                if (bus_err) berr_n++;
            end
            check("hang_stall", 32'(stall_n), 32'd300);
            check("hang_bus_err", 32'(berr_n), 32'd0);
            check("hang_valid", 32'(mem_valid), 32'h1);
            @(posedge clk); #1;
            reset = 1'b1; req = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("hang_recover", 32'(mem_valid), 32'h0);
        end
`endif

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
